// File: rtl/uio_bus_scheduler.sv
// uio_bus_scheduler: owner of the shared bidirectional uio[7:0] pad bus.
// Round-robin arbitration between two byte transmitters (A, B) and one
// byte receiver (RX), with turnaround gaps around each drive burst and a
// fixed hold time for every transmitted byte.
module uio_bus_scheduler #(
    parameter int TURN_CYCLES = 1,   // idle oe=0 cycles around a burst (0..15)
    parameter int HOLD_CYCLES = 2    // cycles each byte is driven (1..15)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    output logic       b_ready,
    input  logic       rx_req,
    input  logic [7:0] uio_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TURN_OUT = 3'd1;
    localparam logic [2:0] S_DRIVE    = 3'd2;
    localparam logic [2:0] S_TURN_IN  = 3'd3;
    localparam logic [2:0] S_SAMPLE   = 3'd4;

    // Requester indices on the ring A -> B -> RX -> A
    localparam logic [1:0] P_A    = 2'd0;
    localparam logic [1:0] P_B    = 2'd1;
    localparam logic [1:0] P_RX   = 2'd2;
    localparam logic [1:0] P_NONE = 2'd3;

    // Counters count down to zero; the load value is "cycles in state - 1"
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam bit         HAS_TURN  = (TURN_CYCLES > 0);

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_ptr;          // requester with highest priority
    logic [7:0] r_byte;         // byte currently owned by the drive burst
    logic [7:0] r_uio_out;
    logic [7:0] r_uio_oe;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;

    logic [3:0] w_req;
    logic [1:0] w_ring_idx [3];
    logic [1:0] w_win;
    logic       w_last_drive;
    logic       w_tx_grant;
    logic       w_rx_grant;
    logic [2:0] w_state_next;
    logic [3:0] w_cnt_next;
    logic [1:0] w_ptr_next;
    logic [7:0] w_byte_next;

    // The RX request is masked in the rx_valid cycle: the receiver only drops
    // rx_req after it has seen rx_valid, so it must not win a second sample.
    assign w_req = {1'b0, rx_req & ~r_rx_valid, b_valid, a_valid} & {4{ena}};

    // Ring order starting at the current priority pointer
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ring
            logic [2:0] w_sum;
            assign w_sum = {1'b0, r_ptr} + 3'(gi);
            assign w_ring_idx[gi] = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
        end
    endgenerate

    // Round-robin winner: scan lowest to highest priority so the highest one sticks
    always_comb begin
        w_win = P_NONE;
        for (int k = 2; k >= 0; k--) begin
            if (w_req[w_ring_idx[k]]) begin
                w_win = w_ring_idx[k];
            end
        end
    end

    assign w_last_drive = (r_state == S_DRIVE) && (r_cnt == 4'd0);
    assign w_tx_grant   = rst_n && ((r_state == S_IDLE) || w_last_drive) &&
                          ((w_win == P_A) || (w_win == P_B));
    assign w_rx_grant   = rst_n && (r_state == S_IDLE) && (w_win == P_RX);
    assign a_ready      = w_tx_grant && (w_win == P_A);
    assign b_ready      = w_tx_grant && (w_win == P_B);

    // Next state, counter reload, priority pointer and byte latch
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ptr_next   = r_ptr;
        w_byte_next  = r_byte;

        if (w_tx_grant) begin
            w_byte_next = (w_win == P_A) ? a_data : b_data;
            w_ptr_next  = (w_win == P_A) ? P_B : P_RX;
        end else if (w_rx_grant) begin
            w_ptr_next = P_A;
        end

        case (r_state)
            S_IDLE: begin
                if (w_tx_grant) begin
                    if (HAS_TURN) begin
                        w_state_next = S_TURN_OUT;
                        w_cnt_next   = TURN_LOAD;
                    end else begin
                        w_state_next = S_DRIVE;
                        w_cnt_next   = HOLD_LOAD;
                    end
                end else if (w_rx_grant) begin
                    w_state_next = S_SAMPLE;
                end
            end
            S_TURN_OUT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_DRIVE;
                    w_cnt_next   = HOLD_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_DRIVE: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else if (w_tx_grant) begin
                    // Back-to-back byte: pads stay driven, no turnaround
                    w_state_next = S_DRIVE;
                    w_cnt_next   = HOLD_LOAD;
                end else if (HAS_TURN) begin
                    w_state_next = S_TURN_IN;
                    w_cnt_next   = TURN_LOAD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_TURN_IN: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_SAMPLE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and registered pad/receive outputs, all updated on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_ptr      <= P_A;
            r_byte     <= 8'h00;
            r_uio_out  <= 8'h00;
            r_uio_oe   <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_ptr      <= w_ptr_next;
            r_byte     <= w_byte_next;
            r_uio_oe   <= (w_state_next == S_DRIVE) ? 8'hFF : 8'h00;
            r_uio_out  <= (w_state_next == S_DRIVE) ? w_byte_next : 8'h00;
            r_rx_valid <= (r_state == S_SAMPLE);
            if (r_state == S_SAMPLE) begin
                r_rx_data <= uio_in;
            end
        end
    end

    assign uio_out  = r_uio_out;
    assign uio_oe   = r_uio_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uio_bus_scheduler.sv
// Testbench for uio_bus_scheduler (TURN_CYCLES=1, HOLD_CYCLES=2).
// Cycle-by-cycle vector table plus a hand-written round-robin sequence.
module tb_uio_bus_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       a_valid = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       a_ready;
    logic       b_valid = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       b_ready;
    logic       rx_req = 1'b0;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uio_bus_scheduler #(.TURN_CYCLES(1), .HOLD_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .rx_req(rx_req), .uio_in(uio_in), .rx_data(rx_data), .rx_valid(rx_valid),
        .uio_out(uio_out), .uio_oe(uio_oe), .busy(busy)
    );

    typedef struct {
        logic       rst_n, ena, av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       rx;
        logic [7:0] uin;
        logic       ar, br;
        logic [7:0] oe, out;
        logic       bsy, rxv;
        logic [7:0] rxd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, e, av, input logic [7:0] ad, input logic bv,
                       input logic [7:0] bd, input logic rx, input logic [7:0] uin,
                       input logic ar, br, input logic [7:0] oe, out,
                       input logic bsy, rxv, input logic [7:0] rxd);
        vec_t v;
        v = '{r, e, av, ad, bv, bd, rx, uin, ar, br, oe, out, bsy, rxv, rxd};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s row %0d: got %02h expected %02h", name, row, act, exp);
        end
    endtask

    initial begin
        int   last_grant;
        int   grants;
        int   wait_cnt;

        // ---- Reset + single TX (A5) ----
        add(0,1,1,8'hA5,1,8'h22,1,8'h00, 0,0,8'h00,8'h00,0,0,8'h00);
        add(0,1,1,8'hA5,1,8'h22,1,8'h00, 0,0,8'h00,8'h00,0,0,8'h00);
        add(1,1,1,8'hA5,0,8'h00,0,8'h00, 1,0,8'h00,8'h00,0,0,8'h00); // c0 grant
        add(1,1,0,8'hA5,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,1,0,8'h00); // c1 TURN_OUT
        add(1,1,0,8'hA5,0,8'h00,0,8'h00, 0,0,8'hFF,8'hA5,1,0,8'h00); // c2 DRIVE
        add(1,1,0,8'hA5,0,8'h00,0,8'h00, 0,0,8'hFF,8'hA5,1,0,8'h00); // c3 DRIVE
        add(1,1,0,8'hA5,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,1,0,8'h00); // c4 TURN_IN
        add(1,1,0,8'hA5,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,0,0,8'h00); // c5 IDLE

        // ---- Contention A/B/RX after a fresh reset ----
        add(0,1,0,8'h00,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,0,0,8'h00);
        add(0,1,0,8'h00,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,0,0,8'h00);
        add(1,1,1,8'h11,1,8'h22,1,8'h3C, 1,0,8'h00,8'h00,0,0,8'h00); // c0 A
        add(1,1,0,8'h11,1,8'h22,1,8'h3C, 0,0,8'h00,8'h00,1,0,8'h00); // c1
        add(1,1,0,8'h11,1,8'h22,1,8'h3C, 0,0,8'hFF,8'h11,1,0,8'h00); // c2
        add(1,1,0,8'h11,1,8'h22,1,8'h3C, 0,1,8'hFF,8'h11,1,0,8'h00); // c3 B chained
        add(1,1,0,8'h11,0,8'h22,1,8'h3C, 0,0,8'hFF,8'h22,1,0,8'h00); // c4
        add(1,1,0,8'h11,0,8'h22,1,8'h3C, 0,0,8'hFF,8'h22,1,0,8'h00); // c5 RX wins
        add(1,1,0,8'h11,0,8'h22,1,8'h3C, 0,0,8'h00,8'h00,1,0,8'h00); // c6 TURN_IN
        add(1,1,0,8'h11,0,8'h22,1,8'h3C, 0,0,8'h00,8'h00,0,0,8'h00); // c7 RX grant
        add(1,1,0,8'h11,0,8'h22,1,8'h3C, 0,0,8'h00,8'h00,1,0,8'h00); // c8 SAMPLE
        add(1,1,0,8'h11,0,8'h22,1,8'h00, 0,0,8'h00,8'h00,0,1,8'h3C); // c9 rx_valid
        add(1,1,0,8'h11,0,8'h22,0,8'h00, 0,0,8'h00,8'h00,0,0,8'h3C); // c10

        // ---- Round robin with back-to-back bytes (pointer at A) ----
        add(1,1,1,8'h01,1,8'h02,0,8'h00, 1,0,8'h00,8'h00,0,0,8'h3C); // d0 A
        add(1,1,1,8'h01,1,8'h02,0,8'h00, 0,0,8'h00,8'h00,1,0,8'h3C);
        add(1,1,1,8'h01,1,8'h02,0,8'h00, 0,0,8'hFF,8'h01,1,0,8'h3C);
        add(1,1,1,8'h01,1,8'h02,0,8'h00, 0,1,8'hFF,8'h01,1,0,8'h3C); // d3 B
        add(1,1,1,8'h01,1,8'h02,0,8'h00, 0,0,8'hFF,8'h02,1,0,8'h3C);
        add(1,1,1,8'h01,1,8'h02,0,8'h00, 1,0,8'hFF,8'h02,1,0,8'h3C); // d5 A
        add(1,1,1,8'h01,1,8'h02,0,8'h00, 0,0,8'hFF,8'h01,1,0,8'h3C);
        add(1,1,1,8'h01,1,8'h02,0,8'h00, 0,1,8'hFF,8'h01,1,0,8'h3C); // d7 B
        add(1,1,1,8'h01,1,8'h02,0,8'h00, 0,0,8'hFF,8'h02,1,0,8'h3C);
        add(1,1,1,8'h01,1,8'h02,0,8'h00, 1,0,8'hFF,8'h02,1,0,8'h3C); // d9 A
        add(1,1,0,8'h01,0,8'h02,0,8'h00, 0,0,8'hFF,8'h01,1,0,8'h3C);
        add(1,1,0,8'h01,0,8'h02,0,8'h00, 0,0,8'hFF,8'h01,1,0,8'h3C);
        add(1,1,0,8'h01,0,8'h02,0,8'h00, 0,0,8'h00,8'h00,1,0,8'h3C);
        add(1,1,0,8'h01,0,8'h02,0,8'h00, 0,0,8'h00,8'h00,0,0,8'h3C);

        // ---- Enable gating ----
        for (int i = 0; i < 5; i++)
            add(1,0,1,8'h5A,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,0,0,8'h3C);
        add(1,1,1,8'h5A,0,8'h00,0,8'h00, 1,0,8'h00,8'h00,0,0,8'h3C); // e5
        add(1,1,0,8'h5A,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,1,0,8'h3C);
        add(1,1,0,8'h5A,0,8'h00,0,8'h00, 0,0,8'hFF,8'h5A,1,0,8'h3C);
        add(1,1,0,8'h5A,0,8'h00,0,8'h00, 0,0,8'hFF,8'h5A,1,0,8'h3C);
        add(1,1,0,8'h5A,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,1,0,8'h3C);
        add(1,1,0,8'h5A,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,0,0,8'h3C);

        // ---- Reset in the middle of a drive ----
        add(0,1,0,8'h00,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,0,0,8'h3C);
        add(0,1,0,8'h00,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,0,0,8'h00);
        add(1,1,1,8'hA5,0,8'h00,0,8'h00, 1,0,8'h00,8'h00,0,0,8'h00); // c0
        add(1,1,0,8'hA5,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,1,0,8'h00); // c1
        add(0,1,0,8'hA5,0,8'h00,0,8'h00, 0,0,8'hFF,8'hA5,1,0,8'h00); // c2 reset
        for (int i = 0; i < 3; i++)
            add(1,1,0,8'hA5,0,8'h00,0,8'h00, 0,0,8'h00,8'h00,0,0,8'h00);

        // Apply table: drive 1 time unit after the edge, check on the falling edge
        for (int r = 0; r < tbl.size(); r++) begin
            @(posedge clk);
            #1;
            rst_n   = tbl[r].rst_n;
            ena     = tbl[r].ena;
            a_valid = tbl[r].av;
            a_data  = tbl[r].ad;
            b_valid = tbl[r].bv;
            b_data  = tbl[r].bd;
            rx_req  = tbl[r].rx;
            uio_in  = tbl[r].uin;
            @(negedge clk);
            chk("a_ready",  r, {7'd0, a_ready},  {7'd0, tbl[r].ar});
            chk("b_ready",  r, {7'd0, b_ready},  {7'd0, tbl[r].br});
            chk("uio_oe",   r, uio_oe,           tbl[r].oe);
            chk("uio_out",  r, uio_out,          tbl[r].out);
            chk("busy",     r, {7'd0, busy},     {7'd0, tbl[r].bsy});
            chk("rx_valid", r, {7'd0, rx_valid}, {7'd0, tbl[r].rxv});
            chk("rx_data",  r, rx_data,          tbl[r].rxd);
            $display("[TB] row %0d rst_n=%0b a_ready=%0b b_ready=%0b oe=%02h out=%02h busy=%0b rx_valid=%0b rx_data=%02h",
                     r, rst_n, a_ready, b_ready, uio_oe, uio_out, busy, rx_valid, rx_data);
        end

        // Hand sequence: continuous A/B requests, grants must alternate starting with A
        last_grant = 1;   // pointer is at A after the last reset, so A must come first
        grants     = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            ena = 1'b1; a_valid = 1'b1; b_valid = 1'b1; rx_req = 1'b0;
            a_data = 8'h33; b_data = 8'h44;
            @(negedge clk);
            chk("ready_exclusive", c, {7'd0, a_ready & b_ready}, 8'h00);
            if (a_ready || b_ready) begin
                grants++;
                chk("rr_alternate", c, {7'd0, b_ready}, (last_grant == 0) ? 8'h01 : 8'h00);
                last_grant = b_ready ? 1 : 0;
                $display("[TB] rr cycle %0d grant %s", c, b_ready ? "B" : "A");
            end
        end
        chk("rr_grant_count", 0, 8'(grants), 8'd12);

        // Release requesters; the burst must wind down within a bounded time
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        wait_cnt = 0;
        @(negedge clk);
        while (busy && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("drain_busy", 0, {7'd0, busy}, 8'h00);
        chk("drain_oe", 0, uio_oe, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
